// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable step, enable and three boundary modes.
// It provides a terminal-count pulse, sticky overflow/underflow flags and one-shot halt control.
module updown_counter_param #(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 2**WIDTH-1,
   parameter int STEP_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              u_d,
   input  logic [STEP_W-1:0] step,
   input  logic [1:0]        mode,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf,
   output logic              unf,
   output logic              running
);

   localparam int AW = WIDTH + STEP_W + 1;

   typedef enum logic [1:0] {
      MODE_WRAP     = 2'b00,
      MODE_SAT      = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_WRAP_ALT = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
   localparam logic [AW-1:0]    MAX_A = AW'(MAX_VAL);
   localparam logic [AW-1:0]    MOD_A = AW'(MAX_VAL + 1);

   mode_e            mode_s;
   logic [AW-1:0]    count_a;
   logic [AW-1:0]    step_a;
   logic [AW-1:0]    up_sum;
   logic [AW-1:0]    dn_diff;
   logic [AW-1:0]    dn_mag;
   logic [AW-1:0]    dn_rem;
   logic [AW-1:0]    wrap_up;
   logic [AW-1:0]    wrap_dn;
   logic             up_over;
   logic             dn_under;
   logic             upd;
   logic [WIDTH-1:0] nxt_count;
   logic             nxt_tc;
   logic             nxt_running;
   logic             ovf_evt;
   logic             unf_evt;
   logic [WIDTH-1:0] load_clamped;

   assign mode_s  = mode_e'(mode);
   assign count_a = AW'(count);
   assign step_a  = AW'(step);
   assign up_sum  = count_a + step_a;
   assign dn_diff = count_a - step_a;
   assign up_over = (up_sum > MAX_A);
   assign dn_under = (step_a > count_a);

   // The step may exceed the modulus, so wrap uses a true modulo rather than a single subtract.
   assign wrap_up = up_sum % MOD_A;
   assign dn_mag  = step_a - count_a;
   assign dn_rem  = dn_mag % MOD_A;
   assign wrap_dn = (dn_rem == '0) ? '0 : (MOD_A - dn_rem);

   assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
   assign upd          = !load && en && running;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      nxt_count   = count;
      nxt_tc      = 1'b0;
      nxt_running = running;
      ovf_evt     = 1'b0;
      unf_evt     = 1'b0;
      if (step != '0) begin
         if (u_d) begin
            if (up_over) begin
               ovf_evt = 1'b1;
               case (mode_s)
                  MODE_SAT: begin
                     nxt_count = MAX_W;
                     nxt_tc    = (count != MAX_W);
                  end
                  MODE_ONESHOT: begin
                     nxt_count   = MAX_W;
                     nxt_tc      = (count != MAX_W);
                     nxt_running = 1'b0;
                  end
                  default: begin
                     nxt_count = WIDTH'(wrap_up);
                     nxt_tc    = 1'b1;
                  end
               endcase
            end else begin
               nxt_count = WIDTH'(up_sum);
               if (up_sum == MAX_A) begin
                  nxt_tc = 1'b1;
                  if (mode_s == MODE_ONESHOT) nxt_running = 1'b0;
               end
            end
         end else begin
            if (dn_under) begin
               unf_evt = 1'b1;
               case (mode_s)
                  MODE_SAT: begin
                     nxt_count = '0;
                     nxt_tc    = (count != '0);
                  end
                  MODE_ONESHOT: begin
                     nxt_count   = '0;
                     nxt_tc      = (count != '0);
                     nxt_running = 1'b0;
                  end
                  default: begin
                     nxt_count = WIDTH'(wrap_dn);
                     nxt_tc    = 1'b1;
                  end
               endcase
            end else begin
               nxt_count = WIDTH'(dn_diff);
               if (dn_diff == '0) begin
                  nxt_tc = 1'b1;
                  if (mode_s == MODE_ONESHOT) nxt_running = 1'b0;
               end
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count   <= '0;
         tc      <= 1'b0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
         running <= 1'b1;
      end else begin
         // A new event in the same cycle as clr_flags leaves the flag set.
         ovf <= (ovf && !clr_flags) || (upd && ovf_evt);
         unf <= (unf && !clr_flags) || (upd && unf_evt);
         if (load) begin
            count   <= load_clamped;
            running <= 1'b1;
            tc      <= 1'b0;
         end else if (upd) begin
            count   <= nxt_count;
            running <= nxt_running;
            tc      <= nxt_tc;
         end else begin
            tc <= 1'b0;
         end
      end
   end

endmodule
